// File: rtl/packet_deframer_pkg.sv
// Shared constants, state encoding and small helpers for the MIX-mode packet deframer
// and the sync correlator.
package packet_deframer_pkg;

   localparam logic [3:0]  MODE_MIX     = 4'b0100;
   localparam int unsigned HDR_SYMS     = 64;
   // Last 64 preamble symbols, oldest symbol in the MSB.
   localparam logic [63:0] SYNC_PATTERN = 64'h5555_5555_AAAA_AAAA;
   localparam logic [7:0]  MOD_BPSK     = 8'hAA;
   localparam logic [7:0]  MOD_QPSK     = 8'h55;

   typedef enum logic [2:0] {
      ST_SEARCH = 3'b001,
      ST_HDR    = 3'b010,
      ST_PLD    = 3'b100
   } state_t;

   function automatic int unsigned popcount64(input logic [63:0] v);
      int unsigned c;
      c = 0;
      for (int i = 0; i < 64; i++) c = c + {31'd0, v[i]};
      return c;
   endfunction

   function automatic int unsigned hamming8(input logic [7:0] a, input logic [7:0] b);
      int unsigned c;
      logic [7:0]  d;
      c = 0;
      d = a ^ b;
      for (int i = 0; i < 8; i++) c = c + {31'd0, d[i]};
      return c;
   endfunction

endpackage

// File: rtl/packet_deframer_sync_correlator.sv
// 64-symbol sliding window correlated against the preamble tail (normal and inverted).
// A hit is only reported once the window has been filled since the last clear.
module sync_correlator
   import packet_deframer_pkg::*;
#(
   parameter int unsigned SYNC_TOL = 4
)(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic shift_en,
   input  logic bit_in,
   output logic hit,
   output logic hit_inv
);

   logic [63:0] window_reg;
   logic [6:0]  fill_reg;
   logic [63:0] window_next;
   logic        full_next;

   // Correlate on the window including the incoming symbol so the header
   // starts with the very next accepted symbol.
   assign window_next = {window_reg[62:0], bit_in};
   assign full_next   = (fill_reg >= 7'd63);
   assign hit     = shift_en & full_next & (popcount64(window_next ^ SYNC_PATTERN) <= SYNC_TOL);
   assign hit_inv = shift_en & full_next & (popcount64(window_next ^ ~SYNC_PATTERN) <= SYNC_TOL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         window_reg <= '0;
         fill_reg   <= '0;
      end else if (clr) begin
         window_reg <= '0;
         fill_reg   <= '0;
      end else if (shift_en) begin
         window_reg <= window_next;
         if (!fill_reg[6]) fill_reg <= fill_reg + 7'd1;
      end
   end

endmodule

// File: rtl/packet_deframer.sv
// MIX-mode RX deframer: preamble sync, header parse, payload forwarding; pass-through otherwise.
// Optional DEFRAMER_PHASE_AMBIG_EN adds detection and correction of an inverted (180 deg) frame.
module packet_deframer
   import packet_deframer_pkg::*;
#(
   parameter int unsigned BYTES    = 1,
   parameter int unsigned SYNC_TOL = 4,
   parameter int unsigned MOD_TOL  = 1
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clk_enable,
   input  logic [3:0]           MODE_CTRL,
   input  logic [BYTES*8-1:0]   I_tdata,
   input  logic                 I_tvalid,
   output logic                 I_tready,
   output logic [BYTES*8-1:0]   O_tdata,
   output logic                 O_tvalid,
   input  logic                 O_tready,
   output logic                 O_tlast,
   output logic                 O_tuser,
   output logic [15:0]          pld_len,
   output logic                 hdr_ok,
   output logic                 hdr_err,
   output logic                 pkt_done
);

   localparam int         W        = BYTES * 8;
   localparam logic [5:0] HDR_LAST = 6'(HDR_SYMS - 1);

   state_t        state_reg, state_next;
   logic [5:0]    hdr_cnt_reg, hdr_cnt_next;
   logic [7:0]    mod_reg, mod_next;
   logic [15:0]   len_reg, len_next;
   logic [15:0]   syms_reg, syms_next;
   logic [15:0]   payload_cnt_reg, payload_cnt_next;
   logic [15:0]   pld_len_reg, pld_len_next;
   logic [W-1:0]  o_tdata_reg, o_tdata_next;
   logic          o_tvalid_reg, o_tvalid_next;
   logic          o_tlast_reg, o_tlast_next;
   logic          o_tuser_reg, o_tuser_next;
   logic          hdr_ok_reg, hdr_ok_next;
   logic          hdr_err_reg, hdr_err_next;
   logic          pkt_done_reg, pkt_done_next;

   logic          mix, accept, out_hs, sym_bit, hit, hit_inv;
   logic          is_bpsk, is_qpsk;
   logic [15:0]   hdr_syms;
   logic [W-1:0]  sym_data;

`ifdef DEFRAMER_PHASE_AMBIG_EN
   logic          inv_reg, inv_next;
   assign sym_data = I_tdata ^ {W{inv_reg}};
`else
   logic          unused_hit_inv;
   assign unused_hit_inv = hit_inv;
   assign sym_data = I_tdata;
`endif

   assign mix      = (MODE_CTRL == MODE_MIX);
   assign accept   = I_tvalid & I_tready & clk_enable;
   assign out_hs   = o_tvalid_reg & O_tready & clk_enable;
   assign sym_bit  = sym_data[0];
   assign is_bpsk  = (hamming8(mod_reg, MOD_BPSK) <= MOD_TOL);
   assign is_qpsk  = ~is_bpsk & (hamming8(mod_reg, MOD_QPSK) <= MOD_TOL);
   assign hdr_syms = is_bpsk ? len_reg : {1'b0, len_reg[15:1]};

   sync_correlator #(.SYNC_TOL(SYNC_TOL)) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (~mix | (state_reg != ST_SEARCH)),
      .shift_en (mix & (state_reg == ST_SEARCH) & accept),
      .bit_in   (sym_bit),
      .hit      (hit),
      .hit_inv  (hit_inv)
   );

   // Once the last payload symbol is taken, stall the input so the next
   // frame's preamble is not swallowed while the final beat waits downstream.
   always_comb begin
      I_tready = 1'b0;
      if (!mix) begin
         I_tready = (state_reg == ST_SEARCH) & O_tready;
      end else begin
         case (state_reg)
            ST_SEARCH, ST_HDR: I_tready = 1'b1;
            ST_PLD:  I_tready = (payload_cnt_reg != syms_reg) & (O_tready | ~o_tvalid_reg);
            default: I_tready = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_next       = state_reg;
      hdr_cnt_next     = hdr_cnt_reg;
      mod_next         = mod_reg;
      len_next         = len_reg;
      syms_next        = syms_reg;
      payload_cnt_next = payload_cnt_reg;
      pld_len_next     = pld_len_reg;
      o_tdata_next     = o_tdata_reg;
      o_tvalid_next    = o_tvalid_reg;
      o_tlast_next     = o_tlast_reg;
      o_tuser_next     = o_tuser_reg;
      hdr_ok_next      = 1'b0;
      hdr_err_next     = 1'b0;
      pkt_done_next    = 1'b0;
`ifdef DEFRAMER_PHASE_AMBIG_EN
      inv_next         = inv_reg;
`endif
      if (!mix) begin
         state_next       = ST_SEARCH;
         hdr_cnt_next     = '0;
         payload_cnt_next = '0;
         o_tlast_next     = 1'b0;
         o_tuser_next     = 1'b1;
`ifdef DEFRAMER_PHASE_AMBIG_EN
         inv_next         = 1'b0;
`endif
         if (state_reg != ST_SEARCH) begin
            o_tvalid_next = 1'b0;
         end else if (clk_enable && O_tready) begin
            o_tdata_next  = I_tdata;
            o_tvalid_next = I_tvalid;
         end
      end else begin
         if (out_hs) begin
            o_tvalid_next = 1'b0;
            o_tlast_next  = 1'b0;
         end
         case (state_reg)
            ST_SEARCH: begin
               if (hit) begin
                  state_next   = ST_HDR;
                  hdr_cnt_next = '0;
`ifdef DEFRAMER_PHASE_AMBIG_EN
                  inv_next     = 1'b0;
               end else if (hit_inv) begin
                  state_next   = ST_HDR;
                  hdr_cnt_next = '0;
                  inv_next     = 1'b1;
`endif
               end
            end
            ST_HDR: begin
               if (accept) begin
                  hdr_cnt_next = hdr_cnt_reg + 6'd1;
                  if (hdr_cnt_reg < 6'd8)       mod_next = {mod_reg[6:0], sym_bit};
                  else if (hdr_cnt_reg < 6'd24) len_next = {len_reg[14:0], sym_bit};
                  if (hdr_cnt_reg == HDR_LAST) begin
                     if ((!is_bpsk && !is_qpsk) || hdr_syms == 16'd0) begin
                        hdr_err_next = 1'b1;
                        state_next   = ST_SEARCH;
`ifdef DEFRAMER_PHASE_AMBIG_EN
                        inv_next     = 1'b0;
`endif
                     end else begin
                        hdr_ok_next      = 1'b1;
                        pld_len_next     = len_reg;
                        o_tuser_next     = is_bpsk;
                        syms_next        = hdr_syms;
                        payload_cnt_next = '0;
                        state_next       = ST_PLD;
                     end
                  end
               end
            end
            ST_PLD: begin
               if (accept) begin
                  o_tdata_next     = sym_data;
                  o_tvalid_next    = 1'b1;
                  o_tlast_next     = (payload_cnt_reg == syms_reg - 16'd1);
                  payload_cnt_next = payload_cnt_reg + 16'd1;
               end
               if (out_hs && o_tlast_reg) begin
                  pkt_done_next = 1'b1;
                  state_next    = ST_SEARCH;
`ifdef DEFRAMER_PHASE_AMBIG_EN
                  inv_next      = 1'b0;
`endif
               end
            end
            default: state_next = ST_SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_SEARCH;
         hdr_cnt_reg     <= '0;
         mod_reg         <= '0;
         len_reg         <= '0;
         syms_reg        <= '0;
         payload_cnt_reg <= '0;
         pld_len_reg     <= '0;
         o_tdata_reg     <= '0;
         o_tvalid_reg    <= 1'b0;
         o_tlast_reg     <= 1'b0;
         o_tuser_reg     <= 1'b1;
         hdr_ok_reg      <= 1'b0;
         hdr_err_reg     <= 1'b0;
         pkt_done_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         hdr_cnt_reg     <= hdr_cnt_next;
         mod_reg         <= mod_next;
         len_reg         <= len_next;
         syms_reg        <= syms_next;
         payload_cnt_reg <= payload_cnt_next;
         pld_len_reg     <= pld_len_next;
         o_tdata_reg     <= o_tdata_next;
         o_tvalid_reg    <= o_tvalid_next;
         o_tlast_reg     <= o_tlast_next;
         o_tuser_reg     <= o_tuser_next;
         hdr_ok_reg      <= hdr_ok_next;
         hdr_err_reg     <= hdr_err_next;
         pkt_done_reg    <= pkt_done_next;
      end
   end

`ifdef DEFRAMER_PHASE_AMBIG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) inv_reg <= 1'b0;
      else        inv_reg <= inv_next;
   end
`endif

   assign O_tdata  = o_tdata_reg;
   assign O_tvalid = o_tvalid_reg;
   assign O_tlast  = o_tlast_reg;
   assign O_tuser  = o_tuser_reg;
   assign pld_len  = pld_len_reg;
   assign hdr_ok   = hdr_ok_reg;
   assign hdr_err  = hdr_err_reg;
   assign pkt_done = pkt_done_reg;

endmodule

// File: tb/tb_packet_deframer.sv
// Directed bench for packet_deframer: framed BPSK/QPSK packets, sync tolerance, header errors,
// downstream stalls, bypass, and reset mid-packet.
module tb_packet_deframer;
   import packet_deframer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clk_enable = 1'b1;
   logic [3:0]  MODE_CTRL = MODE_MIX;
   logic [7:0]  I_tdata = '0;
   logic        I_tvalid = 1'b0;
   logic        I_tready;
   logic [7:0]  O_tdata;
   logic        O_tvalid;
   logic        O_tready;
   logic        O_tlast;
   logic        O_tuser;
   logic [15:0] pld_len;
   logic        hdr_ok, hdr_err, pkt_done;

   int n_checks = 0;
   int n_errors = 0;
   int ok_cnt = 0, err_cnt = 0, done_cnt = 0;
   int rdy_mode = 0;
   bit stall_chk = 1'b0;
   bit stall_on_pld = 1'b0;
   logic [7:0] beat_data[$];
   bit         beat_last[$];
   bit         beat_user[$];

   always #5 clk = ~clk;

   packet_deframer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clk_enable (clk_enable),
      .MODE_CTRL  (MODE_CTRL),
      .I_tdata    (I_tdata),
      .I_tvalid   (I_tvalid),
      .I_tready   (I_tready),
      .O_tdata    (O_tdata),
      .O_tvalid   (O_tvalid),
      .O_tready   (O_tready),
      .O_tlast    (O_tlast),
      .O_tuser    (O_tuser),
      .pld_len    (pld_len),
      .hdr_ok     (hdr_ok),
      .hdr_err    (hdr_err),
      .pkt_done   (pkt_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pay_byte(input int i);
      return 8'((i * 37 + 5) % 256);
   endfunction

   // Downstream ready: 0 = always ready, 2 = toggle for 8 cycles then low for 20.
   initial begin
      int cnt = 0;
      int last_mode = 0;
      O_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode != last_mode) cnt = 0;
         else cnt++;
         last_mode = rdy_mode;
         if (rdy_mode == 0)  O_tready = 1'b1;
         else if (cnt < 8)   O_tready = cnt[0];
         else if (cnt < 28)  O_tready = 1'b0;
         else                O_tready = 1'b1;
      end
   end

   // Monitor: pulses, downstream beats, and hold-while-stalled behaviour.
   initial begin
      bit         prev_stall = 1'b0;
      logic [7:0] prev_data = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (hdr_ok)   ok_cnt++;
            if (hdr_err)  err_cnt++;
            if (pkt_done) done_cnt++;
            if (O_tvalid && O_tready && clk_enable) begin
               beat_data.push_back(O_tdata);
               beat_last.push_back(O_tlast);
               beat_user.push_back(O_tuser);
               $display("beat %0d: data=%02h last=%0b user=%0b", beat_data.size(), O_tdata, O_tlast, O_tuser);
            end
            if (stall_chk && prev_stall) begin
               check("stall_valid", {31'd0, O_tvalid}, 32'd1);
               check("stall_data", {24'd0, O_tdata}, {24'd0, prev_data});
            end
            prev_stall = O_tvalid && !O_tready;
            prev_data  = O_tdata;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   task automatic send_sym(input logic [7:0] d);
      int t = 0;
      bit ok = 1'b0;
      I_tdata  = d;
      I_tvalid = 1'b1;
      while (!ok && t < 200) begin
         @(negedge clk);
         if (I_tready) ok = 1'b1;
         else t++;
      end
      if (!ok) check("tready_timeout", 32'd0, 32'd1);
      else begin
         @(posedge clk);
         #1;
      end
      I_tvalid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] md, input logic [15:0] len, input int npay,
                             input int nflip, input bit inv);
      logic [63:0] pat;
      logic [7:0]  x;
      logic        b;
      pat = SYNC_PATTERN;
      x   = inv ? 8'hFF : 8'h00;
      for (int i = 63; i >= 0; i--) begin
         b = pat[i];
         if (63 - i < nflip) b = ~b;
         send_sym({7'd0, b} ^ x);
      end
      for (int i = 7; i >= 0; i--)  send_sym({7'd0, md[i]} ^ x);
      for (int i = 15; i >= 0; i--) send_sym({7'd0, len[i]} ^ x);
      for (int i = 0; i < 40; i++)  send_sym(x);
      if (stall_on_pld) rdy_mode = 2;
      for (int i = 0; i < npay; i++) send_sym(pay_byte(i) ^ x);
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic wait_done(input string tag, input int base);
      int t = 0;
      while (done_cnt == base && t < 400) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_pkt_done"}, 32'(done_cnt - base), 32'd1);
   endtask

   task automatic check_beats(input string tag, input int base, input int n, input bit user);
      check({tag, "_beats"}, 32'(beat_data.size() - base), 32'(n));
      for (int i = 0; i < n && base + i < beat_data.size(); i++) begin
         check({tag, "_data"}, {24'd0, beat_data[base + i]}, {24'd0, pay_byte(i)});
         check({tag, "_last"}, {31'd0, beat_last[base + i]}, {31'd0, (i == n - 1)});
         check({tag, "_user"}, {31'd0, beat_user[base + i]}, {31'd0, user});
      end
   endtask

   task automatic run_good(input string tag, input logic [7:0] md, input logic [15:0] len,
                           input int nbeats, input int nflip, input bit inv, input bit user);
      int b0 = beat_data.size();
      int o0 = ok_cnt;
      int e0 = err_cnt;
      int d0 = done_cnt;
      send_frame(md, len, nbeats, nflip, inv);
      wait_done(tag, d0);
      wait_cycles(2);
      check({tag, "_hdr_ok"}, 32'(ok_cnt - o0), 32'd1);
      check({tag, "_hdr_err"}, 32'(err_cnt - e0), 32'd0);
      check({tag, "_pld_len"}, {16'd0, pld_len}, {16'd0, len});
      check_beats(tag, b0, nbeats, user);
   endtask

   task automatic run_bad(input string tag, input logic [7:0] md, input logic [15:0] len);
      int b0 = beat_data.size();
      int o0 = ok_cnt;
      int e0 = err_cnt;
      send_frame(md, len, 0, 0, 1'b0);
      wait_cycles(3);
      check({tag, "_hdr_err"}, 32'(err_cnt - e0), 32'd1);
      check({tag, "_hdr_ok"}, 32'(ok_cnt - o0), 32'd0);
      check({tag, "_beats"}, 32'(beat_data.size() - b0), 32'd0);
   endtask

   initial begin
      int b0, o0, e0, d0;
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, o0, e0, d0;
      // Reset state
      #12;
      check("rst_tvalid", {31'd0, O_tvalid}, 32'd0);
      check("rst_tlast", {31'd0, O_tlast}, 32'd0);
      check("rst_tuser", {31'd0, O_tuser}, 32'd1);
      check("rst_pld_len", {16'd0, pld_len}, 32'd0);
      check("rst_pulses", {29'd0, hdr_ok, hdr_err, pkt_done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("search_tready", {31'd0, I_tready}, 32'd1);

      // Clean BPSK, QPSK, QPSK with one mod-byte bit error, sync with 4 flips
      run_good("bpsk16", 8'hAA, 16'd16, 16, 0, 1'b0, 1'b1);
      run_good("qpsk20", 8'h55, 16'd20, 10, 0, 1'b0, 1'b0);
      run_good("qpsk54", 8'h54, 16'd20, 10, 0, 1'b0, 1'b0);
      run_good("flip4", 8'hAA, 16'd4, 4, 4, 1'b0, 1'b1);

      // Five flipped preamble symbols must not lock
      b0 = beat_data.size(); o0 = ok_cnt; e0 = err_cnt;
      send_frame(8'hAA, 16'd16, 0, 5, 1'b0);
      wait_cycles(4);
      check("flip5_hdr_ok", 32'(ok_cnt - o0), 32'd0);
      check("flip5_hdr_err", 32'(err_cnt - e0), 32'd0);
      check("flip5_beats", 32'(beat_data.size() - b0), 32'd0);

      // Bypass: one registered beat, then back to MIX (also empties the window)
      @(posedge clk); #1;
      MODE_CTRL = 4'b0000;
      wait_cycles(2);
      check("byp_tready", {31'd0, I_tready}, {31'd0, O_tready});
      send_sym(8'h3C);
      check("byp_tvalid", {31'd0, O_tvalid}, 32'd1);
      check("byp_tdata", {24'd0, O_tdata}, 32'h3C);
      check("byp_tlast_tuser", {30'd0, O_tlast, O_tuser}, 32'd1);
      @(posedge clk); #1;
      check("byp_tvalid_clr", {31'd0, O_tvalid}, 32'd0);
      MODE_CTRL = MODE_MIX;
      wait_cycles(2);

      // Header rejections
      run_bad("mod_f0", 8'hF0, 16'd16);
      run_bad("len0", 8'hAA, 16'd0);
      run_bad("qpsk_len1", 8'h55, 16'd1);

      // Downstream back-pressure during payload
      stall_on_pld = 1'b1;
      stall_chk    = 1'b1;
      run_good("stall24", 8'hAA, 16'd24, 24, 0, 1'b0, 1'b1);
      stall_on_pld = 1'b0;
      stall_chk    = 1'b0;
      rdy_mode     = 0;
      wait_cycles(2);

      // Reset at payload beat 5, then a clean frame
      b0 = beat_data.size(); d0 = done_cnt;
      send_frame(8'hAA, 16'd16, 5, 0, 1'b0);
      @(negedge clk);
      check("rst5_beats", 32'(beat_data.size() - b0), 32'd5);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("rst5_tvalid", {31'd0, O_tvalid}, 32'd0);
      check("rst5_tuser", {31'd0, O_tuser}, 32'd1);
      check("rst5_pld_len", {16'd0, pld_len}, 32'd0);
      rst_n = 1'b1;
      check("rst5_no_done", 32'(done_cnt - d0), 32'd0);
      wait_cycles(2);
      run_good("after_rst", 8'hAA, 16'd8, 8, 0, 1'b0, 1'b1);

`ifdef DEFRAMER_PHASE_AMBIG_EN
      run_good("inverted", 8'hAA, 16'd8, 8, 0, 1'b1, 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
